// File: rtl/contador_clk_param.sv
// contador_clk_param
//   Clock-enable generator driven entirely from CLK_NX. Produces a fixed
//   pixel-rate tick and N_CH programmable divider channels. Each channel can
//   emit a one-cycle pulse or a 50% duty square wave. A gated copy of one
//   channel's square wave is also produced as the ring/alert output.
//
// Ports
//   CLK_NX      in   1          system clock, rising edge
//   reset       in   1          synchronous, active-high
//   load        in   1          strobe: capture div_in into every channel
//   div_in      in   N_CH*DIV_W channel i divisor at [i*DIV_W +: DIV_W]
//   mode        in   N_CH       0 = pulse, 1 = square (combinational select)
//   ch_en       in   N_CH       per-channel run enable
//   sync        in   1          strobe: realign pixel and channel counters
//   ring_en     in   1          request to gate clk_RING on
//   pixel_rate  out  1          one-cycle enable every PIX_DIV cycles
//   ch_out      out  N_CH       per-channel tick or square
//   clk_RING    out  1          gated square from channel RING_CH

// ---------------------------------------------------------------------------
// contador_clk_ch
//   One divider lane: divisor register, wrap counter, tick/toggle registers
//   and a ring gate. Only the lane selected as RING_CH in the top feeds
//   clk_RING; the gate logic in the other lanes has no load and is pruned.
//
// Ports
//   CLK_NX   in   1      clock
//   reset    in   1      synchronous, active-high
//   load     in   1      capture div_in, clear lane state
//   sync     in   1      clear lane state, keep divisor
//   en       in   1      run enable; low clears and holds the lane
//   ring_en  in   1      gate request, sampled on the tog 0->1 edge
//   div_in   in   DIV_W  new divisor
//   tick     out  1      registered one-cycle pulse on each wrap
//   tog      out  1      toggles on each wrap
//   ring     out  1      tog AND gate, held in its own register
// ---------------------------------------------------------------------------
module contador_clk_ch #(
  parameter int DIV_W   = 24,
  parameter int DEF_DIV = 50000
) (
  input  logic             CLK_NX,
  input  logic             reset,
  input  logic             load,
  input  logic             sync,
  input  logic             en,
  input  logic             ring_en,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick,
  output logic             tog,
  output logic             ring
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic             gate;
  logic             clr;
  logic             wrap;

  // Any of these sources restarts the lane from zero on this edge. A zero
  // divisor is treated as a permanent clear so the lane simply stalls.
  assign clr  = load | sync | ~en | (div_reg == '0);

  // Wrap by compare against div-1: no counter overflow, so the all-ones
  // divisor is a legal setting.
  assign wrap = ~clr & (cnt == (div_reg - ONE));

  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      div_reg <= DEF_V;
      cnt     <= '0;
      tick    <= 1'b0;
      tog     <= 1'b0;
    end else begin
      if (load) div_reg <= div_in;
      if (clr) begin
        cnt  <= '0;
        tick <= 1'b0;
        tog  <= 1'b0;
      end else if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        tog  <= ~tog;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end
    end
  end

  // Gate and ring output are both registered. ring mirrors the next value of
  // (tog & gate): it only rises together with tog, and only falls together
  // with tog or on a lane clear. A ring_en change therefore never cuts or
  // creates a partial high phase, and the output cannot glitch.
  always_ff @(posedge CLK_NX) begin
    if (reset || clr) begin
      gate <= 1'b0;
      ring <= 1'b0;
    end else if (wrap && !tog) begin
      gate <= ring_en;
      ring <= ring_en;
    end else if (wrap && tog) begin
      ring <= 1'b0;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// contador_clk_param (top)
// ---------------------------------------------------------------------------
module contador_clk_param #(
  parameter int PIX_DIV = 4,
  parameter int N_CH    = 3,
  parameter int DIV_W   = 24,
  parameter int DEF_DIV = 50000,
  parameter int RING_CH = 0
) (
  input  logic                  CLK_NX,
  input  logic                  reset,
  input  logic                  load,
  input  logic [N_CH*DIV_W-1:0] div_in,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  sync,
  input  logic                  ring_en,
  output logic                  pixel_rate,
  output logic [N_CH-1:0]       ch_out,
  output logic                  clk_RING
);

  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0]   PIX_LAST  = PW'(PIX_DIV - 1);
  localparam logic [PW-1:0]   PIX_ONE   = PW'(1);
  localparam logic [N_CH-1:0] RING_MASK = N_CH'(1) << RING_CH;

  // ---- pixel-rate tick -----------------------------------------------------
  logic [PW-1:0] pcnt;

  // With PIX_DIV = 1 the counter sits at 0 == PIX_LAST, so the tick is
  // asserted after every edge.
  always_ff @(posedge CLK_NX) begin
    if (reset || sync) begin
      pcnt       <= '0;
      pixel_rate <= 1'b0;
    end else if (pcnt == PIX_LAST) begin
      pcnt       <= '0;
      pixel_rate <= 1'b1;
    end else begin
      pcnt       <= pcnt + PIX_ONE;
      pixel_rate <= 1'b0;
    end
  end

  // ---- divider lanes -------------------------------------------------------
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] tog;
  logic [N_CH-1:0] ring;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    contador_clk_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .CLK_NX  (CLK_NX),
      .reset   (reset),
      .load    (load),
      .sync    (sync),
      .en      (ch_en[i]),
      .ring_en (ring_en),
      .div_in  (div_in[i*DIV_W +: DIV_W]),
      .tick    (tick[i]),
      .tog     (tog[i]),
      .ring    (ring[i])
    );
  end

  // mode is a pure output select between two registered signals; the lane
  // state itself does not depend on it.
  assign ch_out   = (mode & tog) | (~mode & tick);

  // Only the selected lane reaches clk_RING.
  assign clk_RING = |(ring & RING_MASK);

endmodule

// File: tb/tb_contador_clk_param.sv
module tb_contador_clk_param;

  localparam int N_CH  = 3;
  localparam int DIV_W = 24;

  logic                  CLK_NX;
  logic                  reset;
  logic                  load;
  logic [N_CH*DIV_W-1:0] div_in;
  logic [N_CH-1:0]       mode;
  logic [N_CH-1:0]       ch_en;
  logic                  sync;
  logic                  ring_en;
  logic                  pixel_rate;
  logic [N_CH-1:0]       ch_out;
  logic                  clk_RING;

  int n_chk;
  int n_fail;

  contador_clk_param #(
    .PIX_DIV (4),
    .N_CH    (N_CH),
    .DIV_W   (DIV_W),
    .DEF_DIV (50000),
    .RING_CH (0)
  ) dut (
    .CLK_NX     (CLK_NX),
    .reset      (reset),
    .load       (load),
    .div_in     (div_in),
    .mode       (mode),
    .ch_en      (ch_en),
    .sync       (sync),
    .ring_en    (ring_en),
    .pixel_rate (pixel_rate),
    .ch_out     (ch_out),
    .clk_RING   (clk_RING)
  );

  initial CLK_NX = 1'b0;
  always #5 CLK_NX = ~CLK_NX;

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK_NX);
    #1;
  endtask

  task automatic do_load(input logic [N_CH*DIV_W-1:0] d);
    div_in = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({pixel_rate, ch_out, clk_RING} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b expected 00000", {pixel_rate, ch_out, clk_RING});
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_chk++;
      if (pixel_rate !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL pixel_edge%0d: got %b expected %b", k, pixel_rate, (k % 4 == 0));
      end
    end
    pulses = 0;
    for (int k = 0; k < 4000; k++) begin
      step();
      if (pixel_rate === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 1000) begin
      n_fail++;
      $display("FAIL pixel_count: got %0d expected 1000", pulses);
    end
  endtask

  task automatic test_load();
    logic [2:0] e;
    mode  = 3'b010;
    ch_en = 3'b111;
    do_load({24'd5, 24'd3, 24'd2});
    n_chk++;
    if (ch_out !== 3'b000) begin
      n_fail++;
      $display("FAIL load_edge: got %b expected 000", ch_out);
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      e[0] = (k % 2 == 0);
      e[1] = ((k / 3) % 2 == 1);
      e[2] = (k % 5 == 0);
      n_chk++;
      if (ch_out !== e || clk_RING !== 1'b0) begin
        n_fail++;
        $display("FAIL load_k%0d: got ch_out=%b ring=%b expected ch_out=%b ring=0", k, ch_out, clk_RING, e);
      end
    end
  endtask

  task automatic test_reload_sync();
    bit found;
    mode  = 3'b000;
    ch_en = 3'b111;
    do_load({24'd5, 24'd3, 24'd10});
    for (int k = 0; k < 7; k++) step();   // ch0 cnt = 7
    do_load({24'd5, 24'd3, 24'd3});
    for (int k = 1; k <= 3; k++) begin
      step();
      n_chk++;
      if (ch_out[0] !== (k == 3)) begin
        n_fail++;
        $display("FAIL reload_k%0d: got %b expected %b", k, ch_out[0], (k == 3));
      end
    end
    // Align to pixel cnt = 0, then advance to cnt = 2.
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (pixel_rate === 1'b1) found = 1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL pixel_align: got no pulse in 10 cycles expected a pulse");
    end
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++;
      if (pixel_rate !== (k == 4)) begin
        n_fail++;
        $display("FAIL sync_k%0d: got %b expected %b", k, pixel_rate, (k == 4));
      end
    end
  endtask

  task automatic test_enable_zero();
    mode  = 3'b000;
    ch_en = 3'b111;
    do_load({24'd5, 24'd3, 24'd2});
    for (int k = 0; k < 4; k++) step();
    ch_en = 3'b101;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_chk++;
      if (ch_out[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_k%0d: got %b expected 0", k, ch_out[1]);
      end
    end
    ch_en = 3'b111;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_chk++;
      if (ch_out[1] !== (k == 3)) begin
        n_fail++;
        $display("FAIL reenable_k%0d: got %b expected %b", k, ch_out[1], (k == 3));
      end
    end
    mode = 3'b001;
    do_load({24'd5, 24'd3, 24'd0});
    for (int k = 1; k <= 20; k++) begin
      step();
      n_chk++;
      if (ch_out[0] !== 1'b0 || clk_RING !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_div_k%0d: got ch0=%b ring=%b expected 0 0", k, ch_out[0], clk_RING);
      end
    end
  endtask

  task automatic test_ring();
    bit t;
    bit r;
    int run;
    mode    = 3'b001;
    ch_en   = 3'b111;
    ring_en = 1'b0;
    do_load({24'd5, 24'd3, 24'd4});
    run = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      t = ((k / 4) % 2 == 1);
      r = t && (k >= 12) && (k < 28);
      n_chk++;
      if (clk_RING !== r || ch_out[0] !== t) begin
        n_fail++;
        $display("FAIL ring_k%0d: got ring=%b tog=%b expected ring=%b tog=%b", k, clk_RING, ch_out[0], r, t);
      end
      if (clk_RING === 1'b1) run++;
      else if (run > 0) begin
        n_chk++;
        if (run != 4) begin
          n_fail++;
          $display("FAIL ring_width: got %0d expected 4", run);
        end
        run = 0;
      end
      if (k == 5)  ring_en = 1'b1;
      if (k == 21) ring_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit early;
    ring_en = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (clk_RING === 1'b1) found = 1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL ring_arm: got no ring high in 20 cycles expected high");
    end
    reset   = 1'b1;
    ring_en = 1'b0;
    step();
    n_chk++;
    if ({pixel_rate, ch_out, clk_RING} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b expected 00000", {pixel_rate, ch_out, clk_RING});
    end
    reset = 1'b0;
    mode  = 3'b000;
    ch_en = 3'b111;
    early = 0;
    for (int k = 1; k < 50000; k++) begin
      step();
      if (ch_out !== 3'b000) early = 1;
    end
    n_chk++;
    if (early) begin
      n_fail++;
      $display("FAIL default_div_early: got tick before edge 50000 expected none");
    end
    step();
    n_chk++;
    if (ch_out !== 3'b111) begin
      n_fail++;
      $display("FAIL default_div_tick: got %b expected 111", ch_out);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    load    = 1'b0;
    div_in  = '0;
    mode    = '0;
    ch_en   = '0;
    sync    = 1'b0;
    ring_en = 1'b0;
    test_reset();
    test_load();
    test_reload_sync();
    test_enable_zero();
    test_ring();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
